mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single external memory port between the core's instruction-fetch interface and its data-memory interface. Accepts one transaction at a time, chooses the winner round-robin when both sides request, and sequences the memory request/grant/response handshake. Routes the response back to the owning requester, and aborts with an error if memory does not answer within a bounded number of cycles. Sits between `core` and the memory model in `auriga_harness`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 64: maximum cycles in WAIT before an error abort, ≥2.
- `clk_i`, in, 1: clock, rising edge.
- `arst_i`, in, 1: reset, asynchronous, active-high.
- `inst_req_i`, in, 1: fetch request, held until `inst_grnt_o`.
- `inst_addr_i`, in, ADDR_W: fetch address.
- `inst_grnt_o`, out, 1: one-cycle pulse; the fetch request is accepted.
- `inst_data_o`, out, DATA_W: fetch data, valid with `inst_valid_o`.
- `inst_valid_o`, out, 1: one-cycle pulse; fetch response.
- `data_req_i`, in, 1: data request, held until `data_grnt_o`.
- `data_addr_i`, in, ADDR_W: data address.
- `data_wdata_i`, in, DATA_W: write data.
- `data_wen_i`, in, 1: 1 = write, 0 = read.
- `data_grnt_o`, out, 1: one-cycle pulse; the data request is accepted.
- `data_rdata_o`, out, DATA_W: read data, valid with `data_valid_o`.
- `data_valid_o`, out, 1: one-cycle pulse; data response, including the write acknowledge.
- `mem_req_o`, out, 1: memory request.
- `mem_addr_o`, out, ADDR_W: latched address.
- `mem_wdata_o`, out, DATA_W: latched write data. It is 0 for fetches.
- `mem_wen_o`, out, 1: latched write enable. It is 0 for fetches.
- `mem_grnt_i`, in, 1: memory accepts `mem_req_o`.
- `mem_rvalid_i`, in, 1: memory response. Memory answers every transaction, including writes.
- `mem_rdata_i`, in, DATA_W: response data.
- `err_o`, out, 1: one-cycle pulse on a timeout abort.

## Operation
- FSM states are IDLE, ISSUE and WAIT. The registers are `owner` (INST/DATA), `last` (INST/DATA), the latched address/wdata/wen, and a timeout counter of width clog2(TIMEOUT+1).
- **IDLE**
  - No request: stay in IDLE.
  - Winner selection:
    - Only one request: that requester wins.
    - Both request: the requester that is not `last` wins.
  - On the clock edge:
    - Latch the winner's fields.
    - Set `owner` and `last` to the winner.
    - Go to ISSUE.
- **ISSUE**
  - `mem_req_o` = 1.
  - The owner's grant output is 1 in the first ISSUE cycle only. The requester may change its inputs after that.
  - `mem_grnt_i` = 1: go to WAIT and clear the counter.
- **WAIT**
  - `mem_req_o` = 0 and the counter increments each cycle.
  - `mem_rvalid_i` = 1:
    - The owner's valid output = 1 in that same cycle (combinational).
    - The owner's rdata output = `mem_rdata_i`.
    - Go to IDLE.
  - Counter reaches TIMEOUT−1 without a response:
    - Pulse `err_o`.
    - Pulse the owner's valid output with rdata = 0.
    - Go to IDLE.
- The non-owner's grant and valid outputs stay at 0 throughout a transaction. Its request stays pending and is served next.
- `mem_rvalid_i` outside WAIT is ignored, with no output effect.
- The rdata outputs are 0 whenever the matching valid output is 0.

## Timing
- Reset (asynchronous, active-high): state = IDLE and `last` = INST, so DATA wins the first tie. All latched fields and the counter are 0. Every output is 0.
- Reset asserted mid-transaction:
  - The transaction is dropped immediately.
  - No valid or error pulse is produced.
  - A late `mem_rvalid_i` after reset is ignored.
- Latency:
  - Request seen in IDLE at cycle t: `mem_req_o` and the grant pulse appear at t+1.
  - With `mem_grnt_i` at t+1, the FSM is in WAIT at t+2.
  - The earliest response is `mem_rvalid_i` at t+2, with the requester's valid in the same cycle.
  - The next request can be arbitrated at t+3.
- Throughput: at most one transaction per 3 cycles, with one outstanding transaction.
- `mem_req_o` stays high and the fields stay stable through ISSUE until `mem_grnt_i`. There is no timeout in ISSUE.
- `mem_rvalid_i` and the timeout in the same cycle: the response wins, and `err_o` stays 0.
- Alternation: with both requests held continuously, grants alternate DATA, INST, DATA, …

## Test plan
- **Single fetch:** `inst_req_i`=1, addr 0x100. Memory grants immediately and responds next cycle with 0xFCE08793. Required: `inst_grnt_o` at t+1, `mem_addr_o`=0x100, `mem_wen_o`=0, `inst_valid_o` with 0xFCE08793 at t+2, `data_valid_o` stays 0.
- **Simultaneous after reset:** both request, inst addr 0x0, data read addr 0x2000. Required: the data transaction is issued first, then the inst transaction, with exactly one valid pulse each, routed to the correct side.
- **Write:** data write to addr 0x40 with 0xDEADBEEF. Memory holds `mem_grnt_i` low for 3 cycles. Required: `mem_req_o` high for 4 cycles with the fields stable, `mem_wen_o`=1, and `data_valid_o` on the acknowledge.
- **Timeout:** TIMEOUT=4, the memory never responds. Required: `err_o` and `data_valid_o` both pulse 4 cycles after the grant, rdata=0, and the FSM returns to IDLE and serves the next request normally.
- **Stray and mid-operation reset:**
  - `mem_rvalid_i` in IDLE: no outputs.
  - `arst_i` pulsed during WAIT: all outputs are 0 immediately, and the later `mem_rvalid_i` is ignored.
- **Fairness:** both requests held for 20 cycles with single-cycle memory. Required: strictly alternating grants, with DATA first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the instruction
// fetch side and the data side. One transaction in flight at a time, round
// robin on ties, with a bounded wait for the memory response.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_grnt_o,
  output logic [DATA_W-1:0] inst_data_o,
  output logic              inst_valid_o,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic              data_wen_i,
  output logic              data_grnt_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_valid_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_wen_o,
  input  logic              mem_grnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef enum logic {
    SRC_INST,
    SRC_DATA
  } src_t;

  state_t            r_state;
  state_t            w_stateNext;
  src_t              r_owner;
  src_t              r_last;
  src_t              w_winner;
  logic              r_first;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_anyReq;
  logic              w_timeout;

  assign w_anyReq  = inst_req_i | data_req_i;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wen_o   = r_wen;

  // Round-robin pick: a lone requester wins, on a tie the side that did not win last time.
  always_comb begin
    w_winner = SRC_INST;
    if (data_req_i && (!inst_req_i || (r_last == SRC_INST))) begin
      w_winner = SRC_DATA;
    end
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Latch the winner's request, track ownership and count cycles spent waiting.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_owner <= SRC_INST;
      r_last  <= SRC_INST;
      r_first <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_first <= 1'b1;
            if (w_winner == SRC_DATA) begin
              r_addr  <= data_addr_i;
              r_wdata <= data_wdata_i;
              r_wen   <= data_wen_i;
            end else begin
              r_addr  <= inst_addr_i;
              r_wdata <= '0;
              r_wen   <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          r_first <= 1'b0;
          if (mem_grnt_i) begin
            r_cnt <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_first <= 1'b0;
        end
      endcase
    end
  end

  // Next state and all handshake outputs; a response in the timeout cycle still wins.
  always_comb begin
    w_stateNext  = r_state;
    mem_req_o    = 1'b0;
    inst_grnt_o  = 1'b0;
    data_grnt_o  = 1'b0;
    inst_valid_o = 1'b0;
    data_valid_o = 1'b0;
    inst_data_o  = '0;
    data_rdata_o = '0;
    err_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_anyReq) begin
          w_stateNext = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req_o = 1'b1;
        if (r_first) begin
          inst_grnt_o = (r_owner == SRC_INST);
          data_grnt_o = (r_owner == SRC_DATA);
        end
        if (mem_grnt_i) begin
          w_stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_stateNext = S_IDLE;
          if (r_owner == SRC_DATA) begin
            data_valid_o = 1'b1;
            data_rdata_o = mem_rdata_i;
          end else begin
            inst_valid_o = 1'b1;
            inst_data_o  = mem_rdata_i;
          end
        end else if (w_timeout) begin
          w_stateNext = S_IDLE;
          err_o       = 1'b1;
          if (r_owner == SRC_DATA) begin
            data_valid_o = 1'b1;
          end else begin
            inst_valid_o = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

endmodule
